// File: rtl/rx_pkg.sv
// Shared state encoding, error-flag bit positions and length defaults for the
// receive frame controller.
package rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDa,
    StLt,
    StData,
    StDrop
  } rx_state_e;

  // Bit positions inside err_flags.
  localparam int unsigned ErrCode  = 0;
  localparam int unsigned ErrShort = 1;
  localparam int unsigned ErrLong  = 2;
  localparam int unsigned ErrAbort = 3;

  localparam int unsigned MinLenDef   = 64;
  localparam int unsigned MaxLenDef   = 1518;
  localparam int unsigned TagExtraDef = 4;

  // Largest legal byte count, widened by the tag allowance on tagged frames.
  function automatic logic [15:0] len_limit(input logic        is_tagged,
                                            input int unsigned max_len,
                                            input int unsigned tag_extra);
    int unsigned lim;
    lim = max_len + (is_tagged ? tag_extra : 32'd0);
    return lim[15:0];
  endfunction

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Handshake bundle between the receive word decoder and the frame controller.
interface rx_frame_ctrl_if;
  logic        get_sfd;
  logic        get_terminator;
  logic [2:0]  terminator_location;
  logic        get_error_code;
  logic        tagged_frame;
  logic        start_da;
  logic        start_lt;
  logic        rx_busy;
  logic        fifo_wr_en;
  logic        frame_done;
  logic        frame_good;
  logic [15:0] frame_length;
  logic [3:0]  err_flags;

  modport master (
    output get_sfd, get_terminator, terminator_location, get_error_code, tagged_frame,
    input  start_da, start_lt, rx_busy, fifo_wr_en, frame_done, frame_good, frame_length,
           err_flags
  );

  modport slave (
    input  get_sfd, get_terminator, terminator_location, get_error_code, tagged_frame,
    output start_da, start_lt, rx_busy, fifo_wr_en, frame_done, frame_good, frame_length,
           err_flags
  );
endinterface

// File: rtl/rx_len_check.sv
// Combinational runt / oversize classification of a finished frame length.
module rx_len_check
  import rx_pkg::*;
#(
  parameter int unsigned MIN_LEN   = MinLenDef,
  parameter int unsigned MAX_LEN   = MaxLenDef,
  parameter int unsigned TAG_EXTRA = TagExtraDef
) (
  input  logic [15:0] frame_length_i,
  input  logic        tagged_frame_i,
  output logic        too_short_o,
  output logic        too_long_o
);

  assign too_short_o = 32'(frame_length_i) < MIN_LEN;
  assign too_long_o  = frame_length_i > len_limit(tagged_frame_i, MAX_LEN, TAG_EXTRA);

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: tracks DA/LT/DATA phases, counts words, and reports
// length and error status once per frame.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int unsigned MIN_LEN   = MinLenDef,
  parameter int unsigned MAX_LEN   = MaxLenDef,
  parameter int unsigned TAG_EXTRA = TagExtraDef
) (
  input  logic           rxclk,
  input  logic           reset,
  rx_frame_ctrl_if.slave rx_io
);

  rx_state_e   state_q, state_d;
  logic [12:0] word_cnt_q;
  logic        code_q, long_q;
  logic        start_da_q, start_lt_q, busy_q, wr_en_q, done_q, good_q;
  logic [15:0] len_q;
  logic [3:0]  err_q;

  logic        in_frame, overflow, code_now, close, abort;
  logic        too_short, too_long;
  logic [15:0] byte_cnt, close_len;
  logic [3:0]  err_d;

  assign in_frame = state_q inside {StDa, StLt, StData};
  assign byte_cnt = {word_cnt_q, 3'b000};
  assign overflow = (state_q == StData) &&
                    (byte_cnt > len_limit(rx_io.tagged_frame, MAX_LEN, TAG_EXTRA));
  assign code_now = code_q | (rx_io.get_error_code && state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    close     = 1'b0;
    abort     = 1'b0;
    close_len = byte_cnt;
    case (state_q)
      StIdle:  if (rx_io.get_sfd) state_d = StDa;
      StDa:    state_d = StLt;
      StLt:    state_d = StData;
      StData:  if (overflow) state_d = StDrop;
      StDrop:  state_d = StDrop;
      default: state_d = StIdle;
    endcase
    // A terminator always closes normally, even alongside a new SFD.
    if (state_q != StIdle) begin
      if (rx_io.get_terminator) begin
        close     = 1'b1;
        state_d   = rx_io.get_sfd ? StDa : StIdle;
        close_len = (state_q == StDrop) ? 16'hFFFF
                                        : byte_cnt + {13'd0, rx_io.terminator_location};
      end else if (rx_io.get_sfd) begin
        close   = 1'b1;
        abort   = 1'b1;
        state_d = StDa;
      end
    end
  end

  rx_len_check #(
    .MIN_LEN  (MIN_LEN),
    .MAX_LEN  (MAX_LEN),
    .TAG_EXTRA(TAG_EXTRA)
  ) u_len_check (
    .frame_length_i(close_len),
    .tagged_frame_i(rx_io.tagged_frame),
    .too_short_o   (too_short),
    .too_long_o    (too_long)
  );

  always_comb begin
    err_d           = '0;
    err_d[ErrCode]  = code_now;
    err_d[ErrShort] = too_short;
    err_d[ErrLong]  = too_long | long_q;
    err_d[ErrAbort] = abort;
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      code_q     <= 1'b0;
      long_q     <= 1'b0;
      start_da_q <= 1'b0;
      start_lt_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      len_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_da_q <= (state_d == StDa);
      start_lt_q <= (state_d == StLt);
      busy_q     <= (state_d != StIdle);
      wr_en_q    <= state_d inside {StDa, StLt, StData};
      done_q     <= close;

      if (state_d == StDa) begin
        word_cnt_q <= '0;
      end else if (in_frame && word_cnt_q != '1) begin
        word_cnt_q <= word_cnt_q + 13'd1;
      end

      if (close || state_d == StDa) begin
        code_q <= 1'b0;
      end else if (code_now) begin
        code_q <= 1'b1;
      end

      if (close) begin
        long_q <= 1'b0;
      end else if (state_q == StData && state_d == StDrop) begin
        long_q <= 1'b1;
      end

      if (close) begin
        len_q  <= close_len;
        err_q  <= err_d;
        good_q <= ~|err_d;
      end
    end
  end

  assign rx_io.start_da     = start_da_q;
  assign rx_io.start_lt     = start_lt_q;
  assign rx_io.rx_busy      = busy_q;
  assign rx_io.fifo_wr_en   = wr_en_q;
  assign rx_io.frame_done   = done_q;
  assign rx_io.frame_good   = good_q;
  assign rx_io.frame_length = len_q;
  assign rx_io.err_flags    = err_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl; inputs change 1 ns after a rising edge and
// outputs are read at that same point, reflecting the edge just taken.
module tb_rx_frame_ctrl;

  logic rxclk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  rx_frame_ctrl_if bus ();

  rx_frame_ctrl #(
    .MIN_LEN  (64),
    .MAX_LEN  (1518),
    .TAG_EXTRA(4)
  ) dut (
    .rxclk(rxclk),
    .reset(reset),
    .rx_io(bus)
  );

  always #5 rxclk = ~rxclk;

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.get_sfd             = 1'b0;
    bus.get_terminator      = 1'b0;
    bus.terminator_location = 3'd0;
    bus.get_error_code      = 1'b0;
  endtask

  // After this the DUT is in DA with word count 0.
  task automatic start_frame();
    bus.get_sfd = 1'b1;
    tick();
    bus.get_sfd = 1'b0;
  endtask

  task automatic end_frame(input logic [2:0] loc);
    bus.get_terminator      = 1'b1;
    bus.terminator_location = loc;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.tagged_frame = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.start_da !== 1'b0) begin failures++; $display("FAIL rst_start_da got=%0b exp=0", bus.start_da); end
    checks++; if (bus.start_lt !== 1'b0) begin failures++; $display("FAIL rst_start_lt got=%0b exp=0", bus.start_lt); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.rx_busy); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%0b exp=0", bus.fifo_wr_en); end
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'd0) begin failures++; $display("FAIL rst_len got=%0h exp=0", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'd0) begin failures++; $display("FAIL rst_err got=%b exp=0000", bus.err_flags); end
    reset = 1'b0;
    tick();
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%0b exp=0", bus.rx_busy); end
  endtask

  task automatic test_too_short();
    start_frame();
    checks++; if (bus.start_da !== 1'b1) begin failures++; $display("FAIL c1_start_da got=%0b exp=1", bus.start_da); end
    checks++; if (bus.start_lt !== 1'b0) begin failures++; $display("FAIL c1_lt_in_da got=%0b exp=0", bus.start_lt); end
    checks++; if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL c1_busy got=%0b exp=1", bus.rx_busy); end
    tick();
    checks++; if (bus.start_lt !== 1'b1) begin failures++; $display("FAIL c1_start_lt got=%0b exp=1", bus.start_lt); end
    checks++; if (bus.start_da !== 1'b0) begin failures++; $display("FAIL c1_da_in_lt got=%0b exp=0", bus.start_da); end
    repeat (6) tick();
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL c1_early_done got=%0b exp=0", bus.frame_done); end
    end_frame(3'd4);
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL c1_done got=%0b exp=1", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'd60) begin failures++; $display("FAIL c1_len got=%0d exp=60", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b0010) begin failures++; $display("FAIL c1_err got=%b exp=0010", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL c1_good got=%0b exp=0", bus.frame_good); end
    tick();
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL c1_done_pulse got=%0b exp=0", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'd60) begin failures++; $display("FAIL c1_len_hold got=%0d exp=60", bus.frame_length); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL c1_busy_end got=%0b exp=0", bus.rx_busy); end
  endtask

  task automatic test_min_good();
    int wr_cnt;
    wr_cnt = 0;
    start_frame();
    if (bus.fifo_wr_en === 1'b1) wr_cnt++;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.fifo_wr_en === 1'b1) wr_cnt++;
    end
    end_frame(3'd0);
    checks++; if (bus.frame_length !== 16'd64) begin failures++; $display("FAIL c2_len got=%0d exp=64", bus.frame_length); end
    checks++; if (bus.frame_good !== 1'b1) begin failures++; $display("FAIL c2_good got=%0b exp=1", bus.frame_good); end
    checks++; if (bus.err_flags !== 4'b0000) begin failures++; $display("FAIL c2_err got=%b exp=0000", bus.err_flags); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL c2_wr_after got=%0b exp=0", bus.fifo_wr_en); end
    checks++; if (wr_cnt !== 9) begin failures++; $display("FAIL c2_wr_cycles got=%0d exp=9", wr_cnt); end
  endtask

  task automatic test_overflow();
    bus.tagged_frame = 1'b0;
    start_frame();
    repeat (190) tick();
    checks++; if (bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL c3_wr_data got=%0b exp=1", bus.fifo_wr_en); end
    tick();
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL c3_wr_drop got=%0b exp=0", bus.fifo_wr_en); end
    checks++; if (bus.rx_busy !== 1'b1) begin failures++; $display("FAIL c3_busy_drop got=%0b exp=1", bus.rx_busy); end
    repeat (5) tick();
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL c3_wr_drop_hold got=%0b exp=0", bus.fifo_wr_en); end
    end_frame(3'd3);
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL c3_done got=%0b exp=1", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'hFFFF) begin failures++; $display("FAIL c3_len got=%0h exp=ffff", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b0100) begin failures++; $display("FAIL c3_err got=%b exp=0100", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL c3_good got=%0b exp=0", bus.frame_good); end
  endtask

  task automatic test_tagged();
    bus.tagged_frame = 1'b1;
    start_frame();
    repeat (190) tick();
    end_frame(3'd2);
    checks++; if (bus.frame_length !== 16'd1522) begin failures++; $display("FAIL c4t_len got=%0d exp=1522", bus.frame_length); end
    checks++; if (bus.frame_good !== 1'b1) begin failures++; $display("FAIL c4t_good got=%0b exp=1", bus.frame_good); end
    checks++; if (bus.err_flags !== 4'b0000) begin failures++; $display("FAIL c4t_err got=%b exp=0000", bus.err_flags); end
    bus.tagged_frame = 1'b0;
    start_frame();
    repeat (190) tick();
    end_frame(3'd2);
    checks++; if (bus.frame_length !== 16'd1522) begin failures++; $display("FAIL c4u_len got=%0d exp=1522", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b0100) begin failures++; $display("FAIL c4u_err got=%b exp=0100", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL c4u_good got=%0b exp=0", bus.frame_good); end
  endtask

  task automatic test_abort();
    start_frame();
    repeat (20) tick();
    start_frame();
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL c5_done got=%0b exp=1", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'd160) begin failures++; $display("FAIL c5_len got=%0d exp=160", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b1000) begin failures++; $display("FAIL c5_err got=%b exp=1000", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL c5_good got=%0b exp=0", bus.frame_good); end
    checks++; if (bus.start_da !== 1'b1) begin failures++; $display("FAIL c5_new_da got=%0b exp=1", bus.start_da); end
    tick();
    checks++; if (bus.start_lt !== 1'b1) begin failures++; $display("FAIL c5_new_lt got=%0b exp=1", bus.start_lt); end
    repeat (7) tick();
    end_frame(3'd0);
    checks++; if (bus.frame_length !== 16'd64) begin failures++; $display("FAIL c5_next_len got=%0d exp=64", bus.frame_length); end
    checks++; if (bus.frame_good !== 1'b1) begin failures++; $display("FAIL c5_next_good got=%0b exp=1", bus.frame_good); end
  endtask

  task automatic test_error_code();
    start_frame();
    repeat (4) tick();
    bus.get_error_code = 1'b1;
    tick();
    bus.get_error_code = 1'b0;
    repeat (5) tick();
    end_frame(3'd0);
    checks++; if (bus.frame_length !== 16'd80) begin failures++; $display("FAIL c6_len got=%0d exp=80", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b0001) begin failures++; $display("FAIL c6_err got=%b exp=0001", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL c6_good got=%0b exp=0", bus.frame_good); end
  endtask

  task automatic test_idle_ignore();
    bus.get_terminator      = 1'b1;
    bus.get_error_code      = 1'b1;
    bus.terminator_location = 3'd5;
    tick();
    clear_inputs();
    checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL idle_done got=%0b exp=0", bus.frame_done); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", bus.rx_busy); end
    start_frame();
    repeat (8) tick();
    end_frame(3'd0);
    checks++; if (bus.err_flags !== 4'b0000) begin failures++; $display("FAIL idle_err got=%b exp=0000", bus.err_flags); end
    checks++; if (bus.frame_good !== 1'b1) begin failures++; $display("FAIL idle_good got=%0b exp=1", bus.frame_good); end
  endtask

  task automatic test_back_to_back();
    start_frame();
    repeat (9) tick();
    bus.get_sfd             = 1'b1;
    bus.get_terminator      = 1'b1;
    bus.terminator_location = 3'd3;
    tick();
    clear_inputs();
    checks++; if (bus.frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", bus.frame_done); end
    checks++; if (bus.frame_length !== 16'd75) begin failures++; $display("FAIL b2b_len got=%0d exp=75", bus.frame_length); end
    checks++; if (bus.err_flags !== 4'b0000) begin failures++; $display("FAIL b2b_err got=%b exp=0000", bus.err_flags); end
    checks++; if (bus.start_da !== 1'b1) begin failures++; $display("FAIL b2b_da got=%0b exp=1", bus.start_da); end
    repeat (8) tick();
    end_frame(3'd0);
    checks++; if (bus.frame_length !== 16'd64) begin failures++; $display("FAIL b2b_next_len got=%0d exp=64", bus.frame_length); end
    checks++; if (bus.frame_good !== 1'b1) begin failures++; $display("FAIL b2b_next_good got=%0b exp=1", bus.frame_good); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    start_frame();
    repeat (5) tick();
    reset = 1'b1;
    #2;
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", bus.rx_busy); end
    checks++; if (bus.fifo_wr_en !== 1'b0) begin failures++; $display("FAIL rm_wr got=%0b exp=0", bus.fifo_wr_en); end
    checks++; if (bus.frame_good !== 1'b0) begin failures++; $display("FAIL rm_good got=%0b exp=0", bus.frame_good); end
    checks++; if (bus.frame_length !== 16'd0) begin failures++; $display("FAIL rm_len got=%0d exp=0", bus.frame_length); end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.frame_done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL rm_no_done got=%0d exp=0", done_cnt); end
    checks++; if (bus.rx_busy !== 1'b0) begin failures++; $display("FAIL rm_idle got=%0b exp=0", bus.rx_busy); end
  endtask

  initial begin
    test_reset();
    test_too_short();
    test_min_good();
    test_overflow();
    test_tagged();
    test_abort();
    test_error_code();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
